// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 UART transmitter (optional parity), LSB first, idle-high line.
// Ports: clk/rst (async, active high); en low aborts the frame and flushes the FIFO;
// wr_data/wr_valid/wr_ready byte write port; tx serial line; busy while a frame is out;
// done one-cycle pulse at end of each stop bit; level FIFO occupancy.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_n;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [7:0] sh, sh_n;
    logic tx_n, busy_n, done_n, push, pop, empty, last;
    // full refuses writes regardless of a same-cycle pop
    assign wr_ready = en && (level != LW'(FIFO_DEPTH));
    assign push = wr_valid && wr_ready;
    assign empty = level == '0;
    assign last = cnt == CW'(CLKS_PER_BIT - 1);
    always_comb begin
        state_n = state;
        cnt_n = last ? '0 : cnt + 1'b1;
        idx_n = idx;
        sh_n = sh;
        tx_n = tx;
        busy_n = busy;
        done_n = 1'b0;
        pop = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!empty) begin
                    pop = 1'b1;
                    sh_n = mem[rd_ptr];
                    tx_n = 1'b0;
                    busy_n = 1'b1;
                    state_n = START;
                end
            end
            START: if (last) begin
                state_n = DATA;
                idx_n = '0;
                tx_n = sh[0];
            end
            DATA: if (last) begin
                if (idx == 3'd7) begin
                    state_n = PARITY_EN != 0 ? PARITY : STOP;
                    tx_n = PARITY_EN != 0 ? ^sh ^ (PARITY_ODD != 0) : 1'b1;
                end else begin
                    idx_n = idx + 3'd1;
                    tx_n = sh[idx + 3'd1];
                end
            end
            PARITY: if (last) begin
                state_n = STOP;
                tx_n = 1'b1;
            end
            STOP: if (last) begin
                done_n = 1'b1;
                // a queued byte chains straight into the next start bit with no idle gap
                if (!empty) begin
                    pop = 1'b1;
                    sh_n = mem[rd_ptr];
                    tx_n = 1'b0;
                    state_n = START;
                end else begin
                    busy_n = 1'b0;
                    tx_n = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (!en) begin
            state_n = IDLE;
            cnt_n = '0;
            idx_n = '0;
            tx_n = 1'b1;
            busy_n = 1'b0;
            done_n = 1'b0;
            pop = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            sh <= '0;
            tx <= 1'b1;
            busy <= 1'b0;
            done <= 1'b0;
            level <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            idx <= idx_n;
            sh <= sh_n;
            tx <= tx_n;
            busy <= busy_n;
            done <= done_n;
            if (!en) begin
                level <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                level <= level + LW'(push) - LW'(pop);
                wr_ptr <= wr_ptr + AW'(push);
                rd_ptr <= rd_ptr + AW'(pop);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo (plain, even-parity and odd-parity instances).
module tb_uart_tx_fifo;
    localparam int CPB = 8;
    logic clk = 1'b0, rst = 1'b1, en = 1'b1;
    logic [7:0] wr_data = '0;
    logic [2:0] wv = '0;
    wire [2:0] rdy, txv, bsy, dn;
    wire [2:0] lvl0, lvl1, lvl2;
    int checks = 0, failures = 0, cyc = 0, busy_cnt = 0, done_cnt = 0, sel = 0;
    logic [7:0] exp_q [$];

    uart_tx_fifo u0 (.clk(clk), .rst(rst), .en(en), .wr_data(wr_data), .wr_valid(wv[0]), .wr_ready(rdy[0]),
                     .tx(txv[0]), .busy(bsy[0]), .done(dn[0]), .level(lvl0));
    uart_tx_fifo #(.PARITY_EN(1)) u1 (.clk(clk), .rst(rst), .en(en), .wr_data(wr_data), .wr_valid(wv[1]),
                     .wr_ready(rdy[1]), .tx(txv[1]), .busy(bsy[1]), .done(dn[1]), .level(lvl1));
    uart_tx_fifo #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (.clk(clk), .rst(rst), .en(en), .wr_data(wr_data),
                     .wr_valid(wv[2]), .wr_ready(rdy[2]), .tx(txv[2]), .busy(bsy[2]), .done(dn[2]), .level(lvl2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;
    always @(negedge clk) begin
        if (bsy[0]) busy_cnt = busy_cnt + 1;
        if (dn[0]) done_cnt = done_cnt + 1;
    end

    task automatic write_byte(input int s, input logic [7:0] b, input string nm);
        int n = 0;
        wr_data = b;
        wv[s] = 1'b1;
        while (rdy[s] !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (rdy[s] !== 1'b1) begin failures++; $display("FAIL %s write ready=%b expected 1", nm, rdy[s]); end
        else if (s == 0) exp_q.push_back(b);
        @(negedge clk);
        wv[s] = 1'b0;
    endtask

    task automatic wait_start(input string nm);
        int n = 0;
        while (txv[sel] !== 1'b0 && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (txv[sel] !== 1'b0) begin failures++; $display("FAIL %s start_bit tx=%b expected 0", nm, txv[sel]); end
    endtask

    task automatic pop_exp(output logic [7:0] b, input string nm);
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL %s scoreboard_empty size=0 expected >0", nm); b = 8'hxx; end
        else b = exp_q.pop_front();
    endtask

    task automatic check_frame(input logic [7:0] b, input int par, input string nm);
        logic [10:0] fr;
        logic bad, obs;
        int nb;
        nb = par < 0 ? 10 : 11;
        fr = par < 0 ? {2'b11, b, 1'b0} : {1'b1, par[0], b, 1'b0};
        for (int j = 0; j < nb; j++) begin
            bad = 1'b0;
            obs = fr[j];
            for (int c = 0; c < CPB; c++) begin
                if (txv[sel] !== fr[j]) begin bad = 1'b1; obs = txv[sel]; end
                @(negedge clk);
            end
            checks++;
            if (bad) begin failures++; $display("FAIL %s byte=%h bit%0d tx=%b expected %b", nm, b, j, obs, fr[j]); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b1;
        @(negedge clk);
        checks++; if (txv[0] !== 1'b1) begin failures++; $display("FAIL reset_tx tx=%b expected 1", txv[0]); end
        checks++; if (bsy[0] !== 1'b0) begin failures++; $display("FAIL reset_busy busy=%b expected 0", bsy[0]); end
        checks++; if (dn[0] !== 1'b0) begin failures++; $display("FAIL reset_done done=%b expected 0", dn[0]); end
        checks++; if (lvl0 !== 3'd0) begin failures++; $display("FAIL reset_level level=%0d expected 0", lvl0); end
        checks++; if (rdy[0] !== 1'b1) begin failures++; $display("FAIL reset_ready_en1 ready=%b expected 1", rdy[0]); end
        en = 1'b0;
        #1;
        checks++; if (rdy[0] !== 1'b0) begin failures++; $display("FAIL reset_ready_en0 ready=%b expected 0", rdy[0]); end
        en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (txv[0] !== 1'b1) begin failures++; $display("FAIL post_reset_tx tx=%b expected 1", txv[0]); end
    endtask

    task automatic test_single();
        logic [7:0] b;
        sel = 0;
        busy_cnt = 0;
        done_cnt = 0;
        write_byte(0, 8'hA5, "single");
        checks++; if (lvl0 !== 3'd1) begin failures++; $display("FAIL single_level level=%0d expected 1", lvl0); end
        checks++; if (txv[0] !== 1'b1) begin failures++; $display("FAIL single_tx_before tx=%b expected 1", txv[0]); end
        @(negedge clk);
        checks++; if (txv[0] !== 1'b0) begin failures++; $display("FAIL single_latency tx=%b expected 0", txv[0]); end
        checks++; if (bsy[0] !== 1'b1) begin failures++; $display("FAIL single_busy_rise busy=%b expected 1", bsy[0]); end
        pop_exp(b, "single");
        check_frame(b, -1, "single");
        checks++; if (dn[0] !== 1'b1) begin failures++; $display("FAIL single_done done=%b expected 1", dn[0]); end
        checks++; if (bsy[0] !== 1'b0) begin failures++; $display("FAIL single_busy_fall busy=%b expected 0", bsy[0]); end
        @(negedge clk);
        checks++; if (dn[0] !== 1'b0) begin failures++; $display("FAIL single_done_fall done=%b expected 0", dn[0]); end
        @(negedge clk);
        checks++; if (busy_cnt != 80) begin failures++; $display("FAIL single_busy_len busy=%0d expected 80", busy_cnt); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL single_done_count done=%0d expected 1", done_cnt); end
    endtask

    task automatic test_back_to_back();
        int acc [7];
        int dedge [7];
        busy_cnt = 0;
        done_cnt = 0;
        sel = 0;
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    int n;
                    n = 0;
                    wr_data = 8'(i);
                    wv[0] = 1'b1;
                    if (i == 6) begin
                        checks++; if (rdy[0] !== 1'b0) begin failures++; $display("FAIL burst_full_ready ready=%b expected 0", rdy[0]); end
                        checks++; if (lvl0 !== 3'd4) begin failures++; $display("FAIL burst_full_level level=%0d expected 4", lvl0); end
                    end
                    while (rdy[0] !== 1'b1 && n < 300) begin @(negedge clk); n++; end
                    acc[i] = cyc + 1;
                    checks++;
                    if (rdy[0] !== 1'b1) begin failures++; $display("FAIL burst_write%0d ready=%b expected 1", i, rdy[0]); end
                    else exp_q.push_back(8'(i));
                    @(negedge clk);
                end
                wv[0] = 1'b0;
            end
            begin
                logic [7:0] b;
                wait_start("burst");
                for (int f = 1; f <= 6; f++) begin
                    pop_exp(b, "burst");
                    check_frame(b, -1, "burst");
                    dedge[f] = cyc;
                    checks++; if (dn[0] !== 1'b1) begin failures++; $display("FAIL burst_done%0d done=%b expected 1", f, dn[0]); end
                    if (f < 6) begin
                        checks++; if (bsy[0] !== 1'b1) begin failures++; $display("FAIL burst_busy%0d busy=%b expected 1", f, bsy[0]); end
                    end
                end
            end
        join
        for (int i = 2; i <= 5; i++) begin
            checks++; if (acc[i] != acc[1] + i - 1) begin failures++; $display("FAIL burst_accept%0d edge=%0d expected %0d", i, acc[i], acc[1] + i - 1); end
        end
        checks++; if (acc[6] != dedge[1] + 1) begin failures++; $display("FAIL burst_accept6 edge=%0d expected %0d", acc[6], dedge[1] + 1); end
        for (int f = 2; f <= 6; f++) begin
            checks++; if (dedge[f] - dedge[f-1] != 80) begin failures++; $display("FAIL burst_done_gap%0d gap=%0d expected 80", f, dedge[f] - dedge[f-1]); end
        end
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy_cnt != 480) begin failures++; $display("FAIL burst_busy_len busy=%0d expected 480", busy_cnt); end
        checks++; if (done_cnt != 6) begin failures++; $display("FAIL burst_done_count done=%0d expected 6", done_cnt); end
    endtask

    task automatic test_parity();
        int t0;
        for (int s = 1; s <= 2; s++) begin
            sel = s;
            write_byte(s, 8'h07, "parity");
            wait_start("parity");
            t0 = cyc;
            check_frame(8'h07, s == 1 ? 1 : 0, s == 1 ? "parity_even" : "parity_odd");
            checks++; if (dn[s] !== 1'b1) begin failures++; $display("FAIL parity_done%0d done=%b expected 1", s, dn[s]); end
            checks++; if (cyc - t0 != 88) begin failures++; $display("FAIL parity_len%0d len=%0d expected 88", s, cyc - t0); end
            @(negedge clk);
        end
        sel = 0;
    endtask

    task automatic test_en_abort();
        int lows;
        sel = 0;
        done_cnt = 0;
        write_byte(0, 8'h3C, "abort");
        write_byte(0, 8'h5A, "abort");
        write_byte(0, 8'hC3, "abort");
        repeat (33) @(negedge clk);
        checks++; if (txv[0] !== 1'b1) begin failures++; $display("FAIL abort_bit3 tx=%b expected 1", txv[0]); end
        checks++; if (lvl0 !== 3'd2) begin failures++; $display("FAIL abort_queued level=%0d expected 2", lvl0); end
        en = 1'b0;
        wr_data = 8'h99;
        wv[0] = 1'b1;
        @(negedge clk);
        checks++; if (txv[0] !== 1'b1) begin failures++; $display("FAIL abort_tx tx=%b expected 1", txv[0]); end
        checks++; if (bsy[0] !== 1'b0) begin failures++; $display("FAIL abort_busy busy=%b expected 0", bsy[0]); end
        checks++; if (lvl0 !== 3'd0) begin failures++; $display("FAIL abort_level level=%0d expected 0", lvl0); end
        checks++; if (dn[0] !== 1'b0) begin failures++; $display("FAIL abort_done done=%b expected 0", dn[0]); end
        checks++; if (rdy[0] !== 1'b0) begin failures++; $display("FAIL abort_ready ready=%b expected 0", rdy[0]); end
        wv[0] = 1'b0;
        en = 1'b1;
        exp_q.delete();
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (txv[0] !== 1'b1) lows++;
        end
        checks++; if (lows != 0) begin failures++; $display("FAIL abort_idle tx_low_cycles=%0d expected 0", lows); end
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL abort_no_done done=%0d expected 0", done_cnt); end
    endtask

    task automatic test_async_reset();
        logic [7:0] b;
        sel = 0;
        write_byte(0, 8'h81, "arst");
        repeat (20) @(negedge clk);
        checks++; if (bsy[0] !== 1'b1) begin failures++; $display("FAIL arst_inflight busy=%b expected 1", bsy[0]); end
        #2 rst = 1'b1;
        #1;
        checks++; if (txv[0] !== 1'b1) begin failures++; $display("FAIL arst_tx tx=%b expected 1", txv[0]); end
        checks++; if (bsy[0] !== 1'b0) begin failures++; $display("FAIL arst_busy busy=%b expected 0", bsy[0]); end
        checks++; if (lvl0 !== 3'd0) begin failures++; $display("FAIL arst_level level=%0d expected 0", lvl0); end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        write_byte(0, 8'hFF, "arst_ff");
        wait_start("arst_ff");
        pop_exp(b, "arst_ff");
        check_frame(b, -1, "arst_ff");
        write_byte(0, 8'h00, "arst_00");
        wait_start("arst_00");
        pop_exp(b, "arst_00");
        check_frame(b, -1, "arst_00");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_en_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter: the stage directly upstream of the UART receiver, driving the serial line it samples. Accepts bytes over a valid/ready write port into a small FIFO and serialises them as 8N1 frames (optional parity), LSB first, each bit held CLKS_PER_BIT clocks. Default bit timing (8 clocks per bit, line idle high) matches the receiver, so `tx` can be wired straight to its `in` for loopback.

## Interface

- CLKS_PER_BIT, 8: clocks per serial bit; legal range ≥ 2.
- FIFO_DEPTH, 4: FIFO entries; power of two, ≥ 2.
- PARITY_EN, 0: 1 inserts a parity bit between data bit 7 and the stop bit.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd; ignored when PARITY_EN = 0.

- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  enable; low synchronously aborts and flushes.
- wr_data  in  8  byte to enqueue.
- wr_valid  in  1  wr_data is valid this cycle.
- wr_ready  out  1  combinational: en && !full.
- tx  out  1  serial line, registered, idle high.
- busy  out  1  a frame is on the line.
- done  out  1  one-cycle pulse when a frame's stop bit completes.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation

- Write: accepted on a rising edge when wr_valid && wr_ready. A full FIFO refuses writes even if a pop happens in the same cycle.
- FIFO: circular buffer with wrapping pointers. Push and pop in the same cycle leave level unchanged. Byte order is preserved.
- FSM states: IDLE, START, DATA, PARITY, STOP. A bit counter counts 0..CLKS_PER_BIT-1. A 3-bit index selects the data bit.
- IDLE:
  - tx = 1, busy = 0.
  - If en and FIFO non-empty: pop the head into the shift register, compute parity over the 8 bits, set tx <= 0, busy <= 1, go to START.
- START: hold 0 for CLKS_PER_BIT cycles, then go to DATA with tx <= bit 0.
- DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit 7, go to PARITY if PARITY_EN, otherwise go to STOP.
- PARITY: the bit drives XOR of the data, inverted when PARITY_ODD. Held CLKS_PER_BIT cycles.
- STOP: hold 1 for CLKS_PER_BIT cycles. On the last cycle, pulse done.
  - If en and FIFO non-empty: pop and go straight to START (tx <= 0). There is no idle gap and busy stays 1.
  - Otherwise: go to IDLE with busy <= 0.
- Frame length: 10·CLKS_PER_BIT clocks, or 11·CLKS_PER_BIT clocks with parity.
- en low, sampled on any edge:
  - Next state is IDLE with tx = 1, busy = 0, done = 0.
  - The FIFO is flushed (level = 0) and the frame in flight is truncated.
  - wr_ready = 0, so writes are ignored.
  - Normal operation resumes on the first edge with en high.
- Reset: same as en-low flush, but applied asynchronously.

## Timing

- Output values while rst is high and immediately after reset: tx = 1, busy = 0, done = 0, level = 0. wr_ready follows en (the FIFO is empty).
- Latency, write into an idle transmitter with an empty FIFO:
  - Write accepted at edge k.
  - IDLE sees level = 1 at edge k+1 and pops.
  - tx falls after edge k+1.
- busy rises on the same edge that tx falls.
- done rises on the edge that ends the stop bit and falls one clock later. For an isolated frame, busy falls on that same edge.
- tx changes only on bit boundaries; no glitches within a bit period.
- rst asserted mid-frame forces tx = 1 and busy = 0 immediately, without waiting for a clock edge.

## Test plan

- Single byte 0xA5, CLKS_PER_BIT = 8, no parity: tx reads 0,1,0,1,0,0,1,0,1,1, each level held 8 clocks. done pulses once, 80 clocks after tx falls. busy is high for exactly 80 clocks. The receiver in loopback outputs 0xA5 with err = 0.
- Burst 0x01..0x06 offered on consecutive cycles, FIFO_DEPTH = 4:
  - 0x01..0x05 are accepted on 5 consecutive edges.
  - wr_ready is low until 0x02 is popped at the end of the first frame; 0x06 is accepted on the next edge.
  - Six frames go out in order, back-to-back. done pulses are 80 clocks apart and busy never drops in between.
- Parity, byte 0x07 with PARITY_EN = 1: PARITY_ODD = 0 gives parity bit 1; PARITY_ODD = 1 gives 0. Frame length is 88 clocks.
- en dropped during data bit 3 with 2 bytes queued: on the next edge tx = 1, busy = 0, level = 0, and no done pulse. After en returns high, tx stays 1 indefinitely.
- rst pulsed between clock edges mid-frame: tx = 1, busy = 0, level = 0 immediately. A subsequent write of 0xFF produces 0, eight 1s, then 1. A write of 0x00 produces nine 0s, then 1.
